// File: rtl/layer_act_reader.sv
// -----------------------------------------------------------------------------
// layer_act_reader
//
// Read-side counterpart to the activation-buffer writer. Waits for the
// writer's sync token, acknowledges it with a one-cycle pulse and, if the
// token reports a full buffer, reads MEM_SIZE words from the activation BRAM
// (address 0 upward). The words leave as an AXI-stream with TLAST on the
// final word.
//
// Optional build macro:
//   ACT_READER_TUSER_EN : adds ActOut_V_Data_V_TUSER, high on the first word
//                         (address 0) of every frame.
//
// Ports:
//   ap_clk, ap_rst            clock, synchronous active-high reset
//   SyncSig_V, _ap_vld/_ack   sync token from the writer (1 = frame ready,
//                             0 = cancel); ack is a single-cycle pulse
//   ActBuf_Data_V_*           BRAM read port (q0 valid 1 cycle after ce0)
//   ActOut_V_Data_V_*         AXI-stream output (TDATA/TVALID/TREADY/TLAST
//                             [/TUSER])
//
// Stream handshake: a word transfers on every rising edge where TVALID and
// TREADY are both high. Once TVALID is raised, TVALID/TDATA/TLAST/TUSER hold
// their values until that transfer happens; TVALID never waits on TREADY.
// -----------------------------------------------------------------------------
module layer_act_reader #(
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = 10,
  parameter int MEM_SIZE = 768
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              SyncSig_V,
  input  logic              SyncSig_V_ap_vld,
  output logic              SyncSig_V_ap_ack,
  output logic [AWIDTH-1:0] ActBuf_Data_V_address0,
  output logic              ActBuf_Data_V_ce0,
  input  logic [DWIDTH-1:0] ActBuf_Data_V_q0,
  output logic [DWIDTH-1:0] ActOut_V_Data_V_TDATA,
  output logic              ActOut_V_Data_V_TVALID,
  input  logic              ActOut_V_Data_V_TREADY,
  output logic              ActOut_V_Data_V_TLAST
`ifdef ACT_READER_TUSER_EN
  ,
  output logic              ActOut_V_Data_V_TUSER
`endif
);

  // One extra bit so that a count of MEM_SIZE = 2^AWIDTH is representable.
  localparam int CW = AWIDTH + 1;
  localparam logic [CW-1:0] LAST_ADDR = CW'(MEM_SIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACK   = 2'd1,
    S_READ  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              go_q, go_d;
  logic [CW-1:0]     rd_cnt_q, rd_cnt_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic              inflight_q, inflight_d;
  logic              infl_last_q, infl_last_d;

  // Two-entry output FIFO; entry 0 is always the head.
  logic [1:0]        occ_q, occ_d;
  logic [DWIDTH-1:0] data0_q, data0_d, data1_q, data1_d;
  logic              last0_q, last0_d, last1_q, last1_d;

`ifdef ACT_READER_TUSER_EN
  logic              infl_first_q, infl_first_d;
  logic              user0_q, user0_d, user1_q, user1_d;
`endif

  logic              pop;
  logic              issue;
  logic              credit_ok;
  logic [2:0]        used;
  logic [1:0]        occ_after_pop;

  always_comb begin
    state_d     = state_q;
    go_d        = go_q;
    rd_cnt_d    = rd_cnt_q;
    addr_d      = addr_q;
    occ_d       = occ_q;
    data0_d     = data0_q;
    data1_d     = data1_q;
    last0_d     = last0_q;
    last1_d     = last1_q;
`ifdef ACT_READER_TUSER_EN
    user0_d     = user0_q;
    user1_d     = user1_q;
`endif
    issue            = 1'b0;
    SyncSig_V_ap_ack = 1'b0;

    pop = (occ_q != 2'd0) && ActOut_V_Data_V_TREADY;

    // Slots committed = buffered words + word arriving from the BRAM, less
    // the word leaving this cycle. Counting the same-cycle pop keeps one
    // word per cycle flowing with only two entries; a pop requires TREADY=1
    // now, so no word can ever arrive to a full buffer.
    used      = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    credit_ok = (used < 3'd2);

    unique case (state_q)
      S_IDLE: begin
        if (SyncSig_V_ap_vld) begin
          go_d    = SyncSig_V;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        SyncSig_V_ap_ack = 1'b1;
        state_d          = go_q ? S_READ : S_IDLE;
      end
      S_READ: begin
        if (credit_ok) begin
          issue    = 1'b1;
          addr_d   = rd_cnt_q[AWIDTH-1:0];
          rd_cnt_d = rd_cnt_q + CW'(1);
          if (rd_cnt_q == LAST_ADDR) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if ((occ_q == 2'd0) && !inflight_q) begin
          rd_cnt_d = '0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    inflight_d   = issue;
    infl_last_d  = issue && (rd_cnt_q == LAST_ADDR);
`ifdef ACT_READER_TUSER_EN
    infl_first_d = issue && (rd_cnt_q == '0);
`endif

    // Pop shifts entry 1 to the head; the returning BRAM word then lands in
    // the first free slot after that shift.
    if (pop) begin
      data0_d = data1_q;
      last0_d = last1_q;
`ifdef ACT_READER_TUSER_EN
      user0_d = user1_q;
`endif
    end
    occ_after_pop = occ_q - {1'b0, pop};
    if (inflight_q) begin
      if (occ_after_pop == 2'd0) begin
        data0_d = ActBuf_Data_V_q0;
        last0_d = infl_last_q;
`ifdef ACT_READER_TUSER_EN
        user0_d = infl_first_q;
`endif
      end else begin
        data1_d = ActBuf_Data_V_q0;
        last1_d = infl_last_q;
`ifdef ACT_READER_TUSER_EN
        user1_d = infl_first_q;
`endif
      end
    end
    occ_d = occ_after_pop + {1'b0, inflight_q};

    ActBuf_Data_V_ce0      = issue;
    ActBuf_Data_V_address0 = issue ? rd_cnt_q[AWIDTH-1:0] : addr_q;
    ActOut_V_Data_V_TVALID = (occ_q != 2'd0);
    ActOut_V_Data_V_TDATA  = data0_q;
    // Head entry may hold a stale flag once drained; only show it with data.
    ActOut_V_Data_V_TLAST  = (occ_q != 2'd0) && last0_q;
`ifdef ACT_READER_TUSER_EN
    ActOut_V_Data_V_TUSER  = (occ_q != 2'd0) && user0_q;
`endif
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q      <= S_IDLE;
      go_q         <= 1'b0;
      rd_cnt_q     <= '0;
      addr_q       <= '0;
      inflight_q   <= 1'b0;
      infl_last_q  <= 1'b0;
      occ_q        <= 2'd0;
      data0_q      <= '0;
      data1_q      <= '0;
      last0_q      <= 1'b0;
      last1_q      <= 1'b0;
`ifdef ACT_READER_TUSER_EN
      infl_first_q <= 1'b0;
      user0_q      <= 1'b0;
      user1_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      go_q         <= go_d;
      rd_cnt_q     <= rd_cnt_d;
      addr_q       <= addr_d;
      inflight_q   <= inflight_d;
      infl_last_q  <= infl_last_d;
      occ_q        <= occ_d;
      data0_q      <= data0_d;
      data1_q      <= data1_d;
      last0_q      <= last0_d;
      last1_q      <= last1_d;
`ifdef ACT_READER_TUSER_EN
      infl_first_q <= infl_first_d;
      user0_q      <= user0_d;
      user1_q      <= user1_d;
`endif
    end
  end

endmodule
